// File: rtl/rr_slot_alloc_if.sv
// Request/response bundle for the round-robin slot allocator.
// The master side drives the request inputs; the allocator is the slave.
interface rr_slot_alloc_if #(
    parameter int W = 32
);
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);

    logic [W-1:0]  mask_i;
    logic          alloc_vld_i;
    logic          alloc_rdy_o;
    logic          rsp_vld_o;
    logic [IW-1:0] rsp_idx_o;
    logic [W-1:0]  rsp_oh_o;
    logic          free_vld_i;
    logic [IW-1:0] free_idx_i;
    logic          free_err_o;
    logic [CW-1:0] cnt_o;
    logic          full_o;
    logic          empty_o;

    modport master (
        output mask_i, alloc_vld_i, free_vld_i, free_idx_i,
        input  alloc_rdy_o, rsp_vld_o, rsp_idx_o, rsp_oh_o,
        input  free_err_o, cnt_o, full_o, empty_o
    );

    modport slave (
        input  mask_i, alloc_vld_i, free_vld_i, free_idx_i,
        output alloc_rdy_o, rsp_vld_o, rsp_idx_o, rsp_oh_o,
        output free_err_o, cnt_o, full_o, empty_o
    );
endinterface

// File: rtl/rr_slot_alloc.sv
// Circular free-slot allocator: grants the first free, unmasked slot at or after
// a round-robin pointer, with a release port, occupancy count and error flag.
module rr_slot_alloc #(
    parameter int W             = 32,
    parameter bit P_PTR_STICKY  = 1'b1,
    parameter bit P_FREE_BYPASS = 1'b0
) (
    input  logic          clk_i,
    input  logic          rst_i,
    rr_slot_alloc_if.slave bus
);
    localparam int IW = $clog2(W);
    localparam int CW = $clog2(W + 1);
    localparam logic [IW:0] W_EXT = W[IW:0];

    logic [W-1:0]  occ_reg, occ_next;
    logic [IW-1:0] ptr_reg, ptr_next;
    logic [CW-1:0] cnt_reg, cnt_next;
    logic          rsp_vld_reg;
    logic [IW-1:0] rsp_idx_reg;
    logic [W-1:0]  rsp_oh_reg;
    logic          free_err_reg;

    logic [W-1:0]  free_dec, cand, rot, grant_oh;
    logic          free_legal, alloc_rdy, fire;
    logic [IW-1:0] off, slot;
    logic [IW:0]   slot_sum;

    // Indices >= W decode to nothing, which makes them illegal frees for free.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_dec
            assign free_dec[gi] = bus.free_vld_i && (bus.free_idx_i == IW'(gi));
            assign grant_oh[gi] = (slot == IW'(gi));
        end
    endgenerate

    assign free_legal = |(free_dec & occ_reg);
    assign cand = (~occ_reg & ~bus.mask_i) | (P_FREE_BYPASS ? (free_dec & occ_reg) : '0);

    // rot[k] is the candidate k steps past the pointer, modulo W.
    generate
        for (genvar gi = 0; gi < W; gi++) begin : g_rot
            logic [IW:0]   sum;
            logic [IW-1:0] pos;
            assign sum = {1'b0, ptr_reg} + (IW+1)'(gi);
            assign pos = (sum >= W_EXT) ? IW'(sum - W_EXT) : sum[IW-1:0];
            assign rot[gi] = cand[pos];
        end
    endgenerate

    always_comb begin
        off = '0;
        for (int k = W - 1; k >= 0; k--) begin
            if (rot[k]) off = IW'(k);
        end
    end

    assign slot_sum  = {1'b0, ptr_reg} + {1'b0, off};
    assign slot      = (slot_sum >= W_EXT) ? IW'(slot_sum - W_EXT) : slot_sum[IW-1:0];
    assign alloc_rdy = |cand;
    assign fire      = bus.alloc_vld_i & alloc_rdy;

    // Clear before set so a bypassed free-and-regrant of one slot ends occupied.
    assign occ_next = (occ_reg & ~free_dec) | (fire ? grant_oh : '0);
    assign ptr_next = !P_PTR_STICKY ? '0 :
                      (slot == IW'(W - 1)) ? '0 : slot + 1'b1;

    always_comb begin
        cnt_next = cnt_reg;
        case ({fire, free_legal})
            2'b10:   cnt_next = cnt_reg + 1'b1;
            2'b01:   cnt_next = cnt_reg - 1'b1;
            default: cnt_next = cnt_reg;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            occ_reg      <= '0;
            ptr_reg      <= '0;
            cnt_reg      <= '0;
            rsp_vld_reg  <= 1'b0;
            rsp_idx_reg  <= '0;
            rsp_oh_reg   <= '0;
            free_err_reg <= 1'b0;
        end else begin
            occ_reg      <= occ_next;
            cnt_reg      <= cnt_next;
            rsp_vld_reg  <= fire;
            free_err_reg <= bus.free_vld_i & ~free_legal;
            if (fire) begin
                ptr_reg     <= ptr_next;
                rsp_idx_reg <= slot;
                rsp_oh_reg  <= grant_oh;
            end
        end
    end

    assign bus.alloc_rdy_o = alloc_rdy;
    assign bus.rsp_vld_o   = rsp_vld_reg;
    assign bus.rsp_idx_o   = rsp_idx_reg;
    assign bus.rsp_oh_o    = rsp_oh_reg;
    assign bus.free_err_o  = free_err_reg;
    assign bus.cnt_o       = cnt_reg;
    assign bus.full_o      = (cnt_reg == CW'(W));
    assign bus.empty_o     = (cnt_reg == '0);

    a_cnt_popcount: assert property (@(posedge clk_i) disable iff (rst_i)
        cnt_reg == CW'($countones(occ_reg)));
    a_rsp_onehot: assert property (@(posedge clk_i) disable iff (rst_i)
        !rsp_vld_reg || $onehot(rsp_oh_reg));
endmodule

// File: tb/tb_rr_slot_alloc.sv
// Drives four allocator configurations with shared directed and random stimulus
// and compares each against a per-instance slot-table reference model.
module tb_rr_slot_alloc;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst, alloc, fv;
    logic [2:0] fidx;
    logic [7:0] mask;

    int compared   = 0;
    int mismatched = 0;
    int step_no    = 0;

    // 0: W8 sticky, 1: W8 lowest-free, 2: W8 sticky+bypass, 3: W6 sticky
    rr_slot_alloc_if #(.W(8)) b0 ();
    rr_slot_alloc_if #(.W(8)) b1 ();
    rr_slot_alloc_if #(.W(8)) b2 ();
    rr_slot_alloc_if #(.W(6)) b3 ();

    rr_slot_alloc #(.W(8), .P_PTR_STICKY(1'b1), .P_FREE_BYPASS(1'b0)) u0 (.clk_i(clk), .rst_i(rst), .bus(b0));
    rr_slot_alloc #(.W(8), .P_PTR_STICKY(1'b0), .P_FREE_BYPASS(1'b0)) u1 (.clk_i(clk), .rst_i(rst), .bus(b1));
    rr_slot_alloc #(.W(8), .P_PTR_STICKY(1'b1), .P_FREE_BYPASS(1'b1)) u2 (.clk_i(clk), .rst_i(rst), .bus(b2));
    rr_slot_alloc #(.W(6), .P_PTR_STICKY(1'b1), .P_FREE_BYPASS(1'b0)) u3 (.clk_i(clk), .rst_i(rst), .bus(b3));

    assign b0.mask_i = mask;      assign b0.alloc_vld_i = alloc; assign b0.free_vld_i = fv; assign b0.free_idx_i = fidx;
    assign b1.mask_i = mask;      assign b1.alloc_vld_i = alloc; assign b1.free_vld_i = fv; assign b1.free_idx_i = fidx;
    assign b2.mask_i = mask;      assign b2.alloc_vld_i = alloc; assign b2.free_vld_i = fv; assign b2.free_idx_i = fidx;
    assign b3.mask_i = mask[5:0]; assign b3.alloc_vld_i = alloc; assign b3.free_vld_i = fv; assign b3.free_idx_i = fidx;

    logic [31:0] o_rdy[4], o_vld[4], o_idx[4], o_oh[4], o_err[4], o_cnt[4], o_full[4], o_empty[4];
    assign o_rdy[0] = 32'(b0.alloc_rdy_o); assign o_vld[0] = 32'(b0.rsp_vld_o); assign o_idx[0] = 32'(b0.rsp_idx_o); assign o_oh[0] = 32'(b0.rsp_oh_o);
    assign o_err[0] = 32'(b0.free_err_o);  assign o_cnt[0] = 32'(b0.cnt_o);     assign o_full[0] = 32'(b0.full_o);   assign o_empty[0] = 32'(b0.empty_o);
    assign o_rdy[1] = 32'(b1.alloc_rdy_o); assign o_vld[1] = 32'(b1.rsp_vld_o); assign o_idx[1] = 32'(b1.rsp_idx_o); assign o_oh[1] = 32'(b1.rsp_oh_o);
    assign o_err[1] = 32'(b1.free_err_o);  assign o_cnt[1] = 32'(b1.cnt_o);     assign o_full[1] = 32'(b1.full_o);   assign o_empty[1] = 32'(b1.empty_o);
    assign o_rdy[2] = 32'(b2.alloc_rdy_o); assign o_vld[2] = 32'(b2.rsp_vld_o); assign o_idx[2] = 32'(b2.rsp_idx_o); assign o_oh[2] = 32'(b2.rsp_oh_o);
    assign o_err[2] = 32'(b2.free_err_o);  assign o_cnt[2] = 32'(b2.cnt_o);     assign o_full[2] = 32'(b2.full_o);   assign o_empty[2] = 32'(b2.empty_o);
    assign o_rdy[3] = 32'(b3.alloc_rdy_o); assign o_vld[3] = 32'(b3.rsp_vld_o); assign o_idx[3] = 32'(b3.rsp_idx_o); assign o_oh[3] = 32'(b3.rsp_oh_o);
    assign o_err[3] = 32'(b3.free_err_o);  assign o_cnt[3] = 32'(b3.cnt_o);     assign o_full[3] = 32'(b3.full_o);   assign o_empty[3] = 32'(b3.empty_o);

    // Reference model: slot table, pointer and last response per instance.
    int wn[4]     = '{8, 8, 8, 6};
    bit sticky[4] = '{1'b1, 1'b0, 1'b1, 1'b1};
    bit byp[4]    = '{1'b0, 1'b0, 1'b1, 1'b0};
    bit occ_m[4][8];
    int ptr_m[4], ridx_m[4], roh_m[4], cnt_m[4];
    bit rvld_m[4], err_m[4];
    int pend_s[4];
    bit pend_legal[4];

    function automatic bit legal_free(int i);
        return fv && (int'(fidx) < wn[i]) && occ_m[i][fidx];
    endfunction

    function automatic int find_slot(int i);
        bit lf = legal_free(i);
        for (int k = 0; k < wn[i]; k++) begin
            int j = (ptr_m[i] + k) % wn[i];
            if ((!occ_m[i][j] && !mask[j]) || (byp[i] && lf && j == int'(fidx))) return j;
        end
        return -1;
    endfunction

    task automatic chk(input string tag, input int i, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s inst%0d step%0d: observed %0h expected %0h", tag, i, step_no, obs, exp);
        end
    endtask

    task automatic model_update(input int i);
        if (rst) begin
            for (int j = 0; j < 8; j++) occ_m[i][j] = 1'b0;
            ptr_m[i] = 0; ridx_m[i] = 0; roh_m[i] = 0; rvld_m[i] = 1'b0; err_m[i] = 1'b0;
        end else begin
            err_m[i] = fv && !pend_legal[i];
            if (pend_legal[i]) occ_m[i][fidx] = 1'b0;
            rvld_m[i] = alloc && (pend_s[i] >= 0);
            if (rvld_m[i]) begin
                occ_m[i][pend_s[i]] = 1'b1;
                ridx_m[i] = pend_s[i];
                roh_m[i]  = 1 << pend_s[i];
                ptr_m[i]  = sticky[i] ? (pend_s[i] + 1) % wn[i] : 0;
            end
        end
        cnt_m[i] = 0;
        for (int j = 0; j < wn[i]; j++) cnt_m[i] += int'(occ_m[i][j]);
    endtask

    task automatic step(input bit a, input bit f, input int fi, input logic [7:0] m, input bit r);
        rst = r; alloc = a; fv = f; fidx = 3'(fi); mask = m;
        step_no++;
        #2;
        for (int i = 0; i < 4; i++) begin
            pend_s[i]     = find_slot(i);
            pend_legal[i] = legal_free(i);
            chk("alloc_rdy", i, o_rdy[i], 32'(pend_s[i] >= 0));
        end
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) begin
            model_update(i);
            chk("rsp_vld", i, o_vld[i], 32'(rvld_m[i]));
            chk("rsp_idx", i, o_idx[i], 32'(ridx_m[i]));
            chk("rsp_oh", i, o_oh[i], 32'(roh_m[i]));
            chk("free_err", i, o_err[i], 32'(err_m[i]));
            chk("cnt", i, o_cnt[i], 32'(cnt_m[i]));
            chk("full", i, o_full[i], 32'(cnt_m[i] == wn[i]));
            chk("empty", i, o_empty[i], 32'(cnt_m[i] == 0));
        end
        $display("step %0d rst=%0b alloc=%0b free=%0b/%0d mask=%02h | inst0 vld=%0d idx=%0d cnt=%0d err=%0d",
                 step_no, r, a, f, fi, m, o_vld[0], o_idx[0], o_cnt[0], o_err[0]);
    endtask

    initial begin
        rst = 1'b1; alloc = 1'b0; fv = 1'b0; fidx = '0; mask = '0;
        @(posedge clk);
        #1;

        // Fill from reset: sequential grants 0..7, then full and stalled.
        step(0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 8; k++) begin
            step(1, 0, 0, 8'h00, 0);
            chk("fill_idx", 0, o_idx[0], 32'(k));
        end
        chk("fill_full", 0, o_full[0], 32'd1);
        chk("fill_cnt", 0, o_cnt[0], 32'd8);
        chk("fill_rdy", 0, o_rdy[0], 32'd0);

        // Pointer has wrapped to 0: free 2 and 6, then grants 2 then 6.
        step(0, 1, 2, 8'h00, 0);
        step(0, 1, 6, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        chk("wrap_g2", 0, o_idx[0], 32'd2);
        step(1, 0, 0, 8'h00, 0);
        chk("wrap_g6", 0, o_idx[0], 32'd6);

        // Lowest-free policy with a mask.
        step(0, 0, 0, 8'h00, 1);
        step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h02, 0);
        step(1, 0, 0, 8'h02, 0);
        chk("lowfree_mask", 1, o_idx[1], 32'd3);
        step(0, 1, 3, 8'h00, 0);
        step(1, 0, 0, 8'h00, 0);
        chk("lowfree_nomask", 1, o_idx[1], 32'd1);

        // Full, then free 5 with a same-cycle alloc: bypass vs. no bypass.
        step(0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 8; k++) step(1, 0, 0, 8'h00, 0);
        step(1, 1, 5, 8'h00, 0);
        chk("nobyp_vld", 0, o_vld[0], 32'd0);
        chk("nobyp_cnt", 0, o_cnt[0], 32'd7);
        chk("byp_vld", 2, o_vld[2], 32'd1);
        chk("byp_idx", 2, o_idx[2], 32'd5);
        chk("byp_cnt", 2, o_cnt[2], 32'd8);
        step(1, 0, 0, 8'h00, 0);
        chk("nobyp_idx", 0, o_idx[0], 32'd5);
        chk("nobyp_cnt2", 0, o_cnt[0], 32'd8);

        // Out-of-range free on W=6, then free of an empty slot.
        step(0, 1, 7, 8'h00, 0);
        chk("oor_err", 3, o_err[3], 32'd1);
        chk("oor_cnt", 3, o_cnt[3], 32'd6);
        step(0, 0, 0, 8'h00, 0);
        chk("oor_pulse", 3, o_err[3], 32'd0);
        step(0, 0, 0, 8'h00, 1);
        step(0, 1, 4, 8'h00, 0);
        chk("empty_free_err", 0, o_err[0], 32'd1);
        chk("empty_free_cnt", 0, o_cnt[0], 32'd0);

        // Reset colliding with a firing alloc.
        step(0, 0, 0, 8'h00, 1);
        for (int k = 0; k < 4; k++) step(1, 0, 0, 8'h00, 0);
        step(1, 0, 0, 8'h00, 1);
        chk("rst_vld", 0, o_vld[0], 32'd0);
        chk("rst_cnt", 0, o_cnt[0], 32'd0);
        step(1, 0, 0, 8'h00, 0);
        chk("rst_regrant_vld", 0, o_vld[0], 32'd1);
        chk("rst_regrant_idx", 0, o_idx[0], 32'd0);

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            step($urandom_range(0, 3) != 0, $urandom_range(0, 2) == 0, int'($urandom_range(0, 7)),
                 ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'h00, $urandom_range(0, 63) == 0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/rr_slot_alloc.md
Name: rr_slot_alloc

Overview:
- Sequential circular free-slot allocator over a W-entry occupancy vector.
- Each grant takes the first free, unmasked slot at or after a round-robin pointer, scanning upward with wrap-around.
- Adds state the combinational finder lacks: occupancy and pointer registers, a valid/ready alloc handshake, a free port, an occupancy count and an error flag.
- Sits in front of tag/ID pools, e.g. outstanding-transaction tables and buffer-slot managers.

Parameters:
- W, 32, number of slots; W >= 2; need not be a power of two.
- P_PTR_STICKY, 1, pointer policy: 1 = pointer moves to (granted slot + 1) mod W after each grant; 0 = pointer stays at 0, so every search starts at slot 0 (lowest-free policy).
- P_FREE_BYPASS, 0, 1 = a slot freed in cycle t is grantable in cycle t; 0 = grantable from t+1.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  synchronous, active-high reset
- mask_i  in  W  1 = slot excluded from search this cycle; does not change occupancy
- alloc_vld_i  in  1  allocation request
- alloc_rdy_o  out  1  a grantable slot exists this cycle (combinational)
- rsp_vld_o  out  1  registered grant response, one-cycle pulse
- rsp_idx_o  out  $clog2(W)  granted slot index
- rsp_oh_o  out  W  granted slot, one-hot
- free_vld_i  in  1  release request
- free_idx_i  in  $clog2(W)  slot to release
- free_err_o  out  1  registered pulse: illegal free
- cnt_o  out  $clog2(W+1)  number of occupied slots
- full_o  out  1  cnt_o == W
- empty_o  out  1  cnt_o == 0

Behaviour:
- Interface: one clock, clk_i. Reset is synchronous and active-high on rst_i.
- State:
  - occ[W-1:0], occupancy.
  - ptr, $clog2(W) bits, range 0..W-1.
  - cnt.
  - Response registers.
- Reset values: occ=0, ptr=0, cnt_o=0, empty_o=1, full_o=0, rsp_vld_o=0, rsp_idx_o=0, rsp_oh_o=0, free_err_o=0.
- Reset wins over all same-cycle requests. A reset mid-operation discards outstanding grants; no response is issued for a request fired in the reset cycle.
- Candidate vector, cand:
  - P_FREE_BYPASS=0: cand = ~occ & ~mask_i.
  - P_FREE_BYPASS=1: as above, plus bit free_idx_i set when a legal free is presented.
- Search: first set bit of cand scanning ptr, ptr+1, …, W-1, 0, …, ptr-1. Slot ptr itself is eligible.
- alloc_rdy_o = |cand. It depends combinationally on mask_i and, when P_FREE_BYPASS=1, on the free inputs. It never depends on alloc_vld_i.
- Fire = alloc_vld_i & alloc_rdy_o at clock edge t. At edge t:
  - occ[s] is set.
  - ptr becomes (s+1) mod W when P_PTR_STICKY=1; slot W-1 wraps the pointer to 0.
- Response (one-cycle latency): in cycle t+1, rsp_vld_o=1, rsp_idx_o=s, rsp_oh_o=1<<s.
- When there is no fire, rsp_vld_o=0 and rsp_idx_o/rsp_oh_o hold their last value.
- Legal free: free_vld_i & occ[free_idx_i] & (free_idx_i < W). Clears occ[free_idx_i] at the edge.
- Illegal free: the slot is already free, or free_idx_i >= W for non-power-of-two W.
  - No state change.
  - free_err_o=1 in the next cycle.
- Simultaneous alloc and free:
  - cnt is unchanged when both are legal.
  - Alloc and free of the same slot is possible only with P_FREE_BYPASS=1. The slot ends occupied and the grant is valid.
  - With bypass=0, the freed slot is not visible to that cycle's search.
- cnt updates from registered events: +1 on fire, -1 on legal free. It never wraps.
- full_o and empty_o derive from the registered cnt.
- Full case: alloc_rdy_o=0 and a held alloc_vld_i is simply stalled. An empty slot set with all slots masked behaves the same way.
- mask_i bits on occupied slots have no effect.
- Invariant (asserted in RTL): cnt == popcount(occ); rsp_oh_o is one-hot whenever rsp_vld_o=1.

Test Plan:
- W=8, sticky=1, reset, alloc_vld_i held 8 cycles → rsp_idx_o 0,1,…,7 in cycles 1..8; then full_o=1, alloc_rdy_o=0, cnt_o=8.
- W=8, sticky=1, occ=1111_1111, ptr=0. Free slot 2, then free slot 6, then alloc twice → grants 2, then 6. Pointer wraps 7→0 before grant 2.
- W=8, sticky=0, occ=0000_0101, mask_i=0000_0010 → grant slot 3. Same occ with mask 0 → grant slot 1.
- W=8, bypass=0, full, free_idx_i=5 and alloc in the same cycle → no fire that cycle. Next cycle grants 5; cnt_o 8→7→8. Repeat with bypass=1 → grant 5 in the same cycle, cnt_o stays 8.
- Free of unoccupied slot 4 → free_err_o pulses 1 cycle, occ and cnt_o unchanged. W=6 with free_idx_i=7 → free_err_o pulses.
- Reset asserted in the same cycle as a firing alloc, with occ=0000_1111 → next cycle rsp_vld_o=0, cnt_o=0, ptr=0; the next alloc grants slot 0.
